system_bus_ram: RTL
===================

# system_bus_ram

Single-port, word-addressed block RAM that acts as a responder on the system bus, the target side of the bus the CPU drives. It accepts one read or write per cycle while `bus_ready` is high. Writes honour byte enables. Read data returns in order after a fixed, parameterised latency on `bus_read_data`/`bus_read_data_valid`. An interconnect places it behind an address decoder and routes its ready, read data and read-data-valid back to the CPU.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: word-address bits used to index the RAM (2^12 words = 16 KiB).
- `READ_LATENCY`, default 2: cycles from read acceptance to `bus_read_data_valid`. Legal range 1..4; any other value is an elaboration-time `$error`.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `bus_ready`  out  1  responder can accept a request this cycle.
- `bus_addr`  in  30  word address. Only `[ADDR_WIDTH-1:0]` is used; the upper bits are ignored because decoding happens upstream.
- `bus_write_data`  in  32  write data.
- `bus_byte_enable`  in  4  byte lane `i` enables `bus_write_data[8i+7:8i]`.
- `bus_write_req`  in  1  write request.
- `bus_read_req`  in  1  read request.
- `bus_read_data`  out  32  read data.
- `bus_read_data_valid`  out  1  `bus_read_data` is valid this cycle.

## Operation
- A request is accepted on any rising edge where (`bus_read_req` | `bus_write_req`) & `bus_ready`.
- Requests presented while `bus_ready` is low are neither accepted nor remembered. The initiator holds them.
- **Write accept:**
  - Each byte lane with its enable set updates the addressed word at that edge.
  - Lanes with the enable clear keep their old contents.
  - `bus_byte_enable` = 4'b0000 is a legal no-op write.
- **Read accept:**
  - The RAM array is read at the accept edge.
  - The result is carried through a `READ_LATENCY`-deep valid/data pipeline.
- **Simultaneous read and write requests:**
  - This is illegal per the bus protocol.
  - The block treats it as a write only: the read is dropped and produces no valid.
- **Read-after-write:**
  - A read accepted in the cycle after a write to the same word returns the new data.
  - No read and write to the same address can coincide, because there is one request per cycle.
- **Read throughput:**
  - Fully pipelined, up to one read accepted per cycle.
  - Valids come back in acceptance order, one per cycle, with no gaps beyond the gaps in acceptance.
- **Response path independence:**
  - The response pipeline never stalls.
  - Valids already in flight are delivered regardless of `bus_ready`.
- **Reset:**
  - `bus_ready` = 0.
  - `bus_read_data_valid` = 0.
  - `bus_read_data` = 32'h0.
  - All pipeline valid bits are cleared, so reads in flight are discarded and never return.
  - RAM contents are not cleared.
- **`bus_read_data` between valids:**
  - It holds its last value.
  - Consumers must qualify it with `bus_read_data_valid`.

## Timing
- `bus_ready` is registered.
  - It is 0 in every cycle with `reset` high.
  - It is 1 from the first cycle after `reset` falls, unless the stall feature is compiled in.
- Read latency:
  - A read accepted at edge N gives `bus_read_data_valid` = 1 during the cycle following edge N+`READ_LATENCY`-1.
  - With `READ_LATENCY`=1, valid appears in the cycle immediately after acceptance.
- Write latency: a write is visible to a read accepted at the very next edge.
- `bus_read_data_valid` is high for exactly one cycle per accepted read.
- Reset asserted mid-burst:
  - The outputs listed under Reset take their reset values in the first cycle following the edge where `reset` is sampled high.
  - No stale valid appears after reset.
- Combinational paths: there are no input-to-output combinational paths. All outputs are registered.

## Configuration
- Macro: `SYSTEM_BUS_RAM_STALL_EN`.
- **Defined:** `bus_ready` is driven by pseudo-random back-pressure.
  - A 16-bit Fibonacci LFSR with taps 16,14,13,11 is seeded to 16'hACE1 by reset and advances every cycle.
  - `bus_ready` is registered as `lfsr[0] | lfsr[1]`, giving about 75% availability.
  - `bus_ready` is still 0 while `reset` is high.
  - The response pipeline is unaffected.
  - This exists to exercise the CPU's and interconnect's handling of `bus_ready`.
- **Undefined:** no LFSR logic is present, and `bus_ready` is constant 1 out of reset.

## Test plan
- **Reset values:** hold `reset` for 3 cycles with random requests on the bus -> `bus_ready`=0, `bus_read_data_valid`=0 and `bus_read_data`=0 throughout; `bus_ready`=1 in the first cycle after release (macro undefined).
- **Byte-enable write:**
  - Write 32'hDEADBEEF to addr 5 with byte enable 4'hF, then 32'h11223344 to addr 5 with byte enable 4'b0101.
  - Then read addr 5 -> data 32'hDE22BE44 with valid exactly `READ_LATENCY` cycles after acceptance.
- **Back-to-back reads (`READ_LATENCY`=3):**
  - Preload addr 0..7 with 32'h100+addr, then issue reads of addr 0..7 on 8 consecutive cycles.
  - Expect 8 consecutive valids carrying 32'h100..32'h107 in order, the first appearing in the 3rd cycle after the first acceptance.
- **Read-after-write:** write 32'hCAFEF00D to addr 9, read addr 9 on the next cycle -> 32'hCAFEF00D.
- **Reset mid-pipeline:**
  - Issue 2 reads with `READ_LATENCY`=4, then assert `reset` 1 cycle after the second acceptance.
  - Expect no valid ever returned for either read; RAM contents at both addresses are unchanged afterwards.
- **Stall build (macro defined):**
  - Run 10,000 random reads and writes against a reference model, with requests held until accepted.
  - Expect all data to match, `bus_ready` duty between 70% and 80%, and no valid emitted for any cycle whose request was not accepted.

Source files
------------

// File: rtl/system_bus_ram.sv
// Word-addressed block RAM responder on the system bus: byte-enabled writes, fixed-latency pipelined reads.
// Define SYSTEM_BUS_RAM_STALL_EN to drive bus_ready from pseudo-random LFSR back-pressure.
module system_bus_ram #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        bus_ready,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_write_req,
  input  logic        bus_read_req,
  output logic [31:0] bus_read_data,
  output logic        bus_read_data_valid
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

  if (READ_LATENCY == 0 || READ_LATENCY > 4) begin : g_bad_latency
    $error("system_bus_ram: READ_LATENCY must be in the range 1..4");
  end

  logic                    ready_q;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    unused_addr;
  logic [31:0]             mem [DEPTH];
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [31:0]             dat_pipe [READ_LATENCY];

  // Upper address bits are decoded upstream.
  assign word_idx    = bus_addr[ADDR_WIDTH-1:0];
  assign unused_addr = ^bus_addr[29:ADDR_WIDTH];

  // A simultaneous read and write is treated as a write only.
  assign wr_fire = bus_write_req & ready_q & ~reset;
  assign rd_fire = bus_read_req & ~bus_write_req & ready_q & ~reset;

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_byte_enable[i]) begin
          mem[word_idx][8*i +: 8] <= bus_write_data[8*i +: 8];
        end
      end
    end
  end

  // Response pipeline: never stalls; each data stage only loads alongside a valid,
  // so the last stage holds its value between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        dat_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_fire;
      if (rd_fire) begin
        dat_pipe[0] <= mem[word_idx];
      end
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) begin
          dat_pipe[i] <= dat_pipe[i-1];
        end
      end
    end
  end

`ifdef SYSTEM_BUS_RAM_STALL_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr    <= 16'hACE1;
      ready_q <= 1'b0;
    end else begin
      lfsr    <= {lfsr_fb, lfsr[15:1]};
      ready_q <= lfsr[0] | lfsr[1];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end
`endif

  assign bus_ready           = ready_q;
  assign bus_read_data_valid = vld_pipe[READ_LATENCY-1];
  assign bus_read_data       = dat_pipe[READ_LATENCY-1];

endmodule
